// File: rtl/ex_muldiv_pkg.sv
// ============================================================================
// ex_muldiv_pkg : shared RV32M opcodes, FSM encodings and signedness helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package ex_muldiv_pkg;

   localparam logic [6:0] INST_M_FUNCT7 = 7'b0000001;

   localparam logic [2:0] INST_MUL    = 3'b000;
   localparam logic [2:0] INST_MULH   = 3'b001;
   localparam logic [2:0] INST_MULHSU = 3'b010;
   localparam logic [2:0] INST_MULHU  = 3'b011;
   localparam logic [2:0] INST_DIV    = 3'b100;
   localparam logic [2:0] INST_DIVU   = 3'b101;
   localparam logic [2:0] INST_REM    = 3'b110;
   localparam logic [2:0] INST_REMU   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   function automatic logic op1_is_signed(input logic [2:0] op);
      return (op == INST_MULH) || (op == INST_MULHSU) || (op == INST_DIV) || (op == INST_REM);
   endfunction

   // MULHSU treats rs2 as unsigned
   function automatic logic op2_is_signed(input logic [2:0] op);
      return (op == INST_MULH) || (op == INST_DIV) || (op == INST_REM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_div_core.sv
// ============================================================================
// muldiv_div_core : iterative radix-2 restoring divider on unsigned magnitudes
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_div_core #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            done_o,
   output logic [XLEN-1:0] quot_o,
   output logic [XLEN-1:0] rem_o
);

   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_quot;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_divisor;

   logic [XLEN:0]    w_shift;
   logic [XLEN:0]    w_diff;
   logic             w_fits;
   logic [XLEN-1:0]  w_quot_nxt;
   logic [XLEN-1:0]  w_rem_nxt;

   // r_quot doubles as the dividend shift register; its MSB feeds the partial remainder
   assign w_shift    = {r_rem, r_quot[XLEN-1]};
   assign w_diff     = w_shift - {1'b0, r_divisor};
   assign w_fits     = ~w_diff[XLEN];
   assign w_rem_nxt  = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
   assign w_quot_nxt = {r_quot[XLEN-2:0], w_fits};

   // Results are presented combinationally during the last iteration
   assign done_o = r_busy & (r_cnt == CNT_W'(XLEN - 1));
   assign quot_o = w_quot_nxt;
   assign rem_o  = w_rem_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy    <= 1'b0;
         r_cnt     <= '0;
         r_quot    <= '0;
         r_rem     <= '0;
         r_divisor <= '0;
      end else if (abort_i) begin
         r_busy <= 1'b0;
      end else if (start_i) begin
         r_busy    <= 1'b1;
         r_cnt     <= '0;
         r_quot    <= dividend_i;
         r_rem     <= '0;
         r_divisor <= divisor_i;
      end else if (r_busy) begin
         r_quot <= w_quot_nxt;
         r_rem  <= w_rem_nxt;
         r_cnt  <= r_cnt + CNT_W'(1);
         if (done_o) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ============================================================================
// ex_muldiv : RV32M multi-cycle multiply/divide unit beside the ex stage
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_ITER = 0,
   parameter int CNT_W    = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            flush_i,
   output logic            hold_flag_o,
   output logic            busy_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic [4:0]      rd_addr_o,
   output logic            rd_wen_o
);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [2:0]        r_op;
   logic [4:0]        r_rd_addr;
   logic [XLEN-1:0]   r_abs1;
   logic [XLEN-1:0]   r_abs2;
   logic [XLEN-1:0]   r_result;
   logic              r_neg_res;
   logic              r_neg_rem;

   logic              w_accept;
   logic              w_neg1;
   logic              w_neg2;
   logic [XLEN-1:0]   w_abs1;
   logic [XLEN-1:0]   w_abs2;
   logic              w_div_zero;
   logic              w_div_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_special_res;
   logic [2*XLEN-1:0] w_prod_mag;
   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0]   w_mul_res;
   logic              w_mul_last;
   logic              w_div_done;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_div_res;

   assign w_accept = (r_state == ST_IDLE) & start_i & ~flush_i;

   assign w_neg1 = op1_is_signed(op_i) & op1_i[XLEN-1];
   assign w_neg2 = op2_is_signed(op_i) & op2_i[XLEN-1];
   assign w_abs1 = w_neg1 ? -op1_i : op1_i;
   assign w_abs2 = w_neg2 ? -op2_i : op2_i;

   // Divide-by-zero and signed overflow bypass the iterative divider
   assign w_div_zero = (op2_i == '0);
   assign w_div_ovf  = ((op_i == INST_DIV) || (op_i == INST_REM)) &&
                       (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
   assign w_special  = op_i[2] & (w_div_zero | w_div_ovf);

   always_comb begin
      w_special_res = '0;
      if (op_i[1]) begin
         w_special_res = w_div_zero ? op1_i : '0;
      end else begin
         w_special_res = w_div_zero ? '1 : op1_i;
      end
   end

   generate
      if (MUL_ITER == 0) begin : g_mul_comb
         assign w_prod_mag = {{XLEN{1'b0}}, r_abs1} * {{XLEN{1'b0}}, r_abs2};
         assign w_mul_last = 1'b1;
      end else begin : g_mul_iter
         logic [CNT_W-1:0]  r_cnt;
         logic [2*XLEN-1:0] r_prod;
         logic [2*XLEN-1:0] w_prod_cur;
         logic [XLEN:0]     w_sum;

         // Low half holds the unconsumed multiplier bits; seeded on the first MUL cycle
         assign w_prod_cur = (r_cnt == '0) ? {{XLEN{1'b0}}, r_abs2} : r_prod;
         assign w_sum      = {1'b0, w_prod_cur[2*XLEN-1:XLEN]} +
                             (w_prod_cur[0] ? {1'b0, r_abs1} : {(XLEN+1){1'b0}});
         assign w_prod_mag = {w_sum, w_prod_cur[XLEN-1:1]};
         assign w_mul_last = (r_cnt == CNT_W'(XLEN - 1));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt  <= '0;
               r_prod <= '0;
            end else if (w_accept) begin
               r_cnt <= '0;
            end else if (r_state == ST_MUL) begin
               r_cnt  <= r_cnt + CNT_W'(1);
               r_prod <= w_prod_mag;
            end
         end
      end
   endgenerate

   assign w_prod_fix = r_neg_res ? -w_prod_mag : w_prod_mag;
   assign w_mul_res  = (r_op == INST_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
   assign w_div_res  = r_op[1] ? (r_neg_rem ? -w_rem : w_rem)
                               : (r_neg_res ? -w_quot : w_quot);

   muldiv_div_core #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) u_div_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (w_accept & op_i[2] & ~w_special),
      .abort_i    ((r_state == ST_DIV) & flush_i),
      .dividend_i (w_abs1),
      .divisor_i  (w_abs2),
      .done_o     (w_div_done),
      .quot_o     (w_quot),
      .rem_o      (w_rem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = !op_i[2] ? ST_MUL : (w_special ? ST_DONE : ST_DIV);
            end
         end
         ST_MUL: begin
            if (flush_i)         w_state_nxt = ST_IDLE;
            else if (w_mul_last) w_state_nxt = ST_DONE;
         end
         ST_DIV: begin
            if (flush_i)         w_state_nxt = ST_IDLE;
            else if (w_div_done) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      hold_flag_o = 1'b0;
      busy_o      = (r_state != ST_IDLE);
      rd_wen_o    = 1'b0;
      rd_data_o   = '0;
      rd_addr_o   = '0;
      case (r_state)
         ST_IDLE: hold_flag_o = start_i & ~flush_i;
         ST_MUL:  hold_flag_o = 1'b1;
         ST_DIV:  hold_flag_o = 1'b1;
         default: begin
            rd_wen_o  = 1'b1;
            rd_data_o = r_result;
            rd_addr_o = r_rd_addr;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= '0;
         r_rd_addr <= '0;
         r_abs1    <= '0;
         r_abs2    <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_result  <= '0;
      end else if (w_accept) begin
         r_op      <= op_i;
         r_rd_addr <= rd_addr_i;
         r_abs1    <= w_abs1;
         r_abs2    <= w_abs2;
         r_neg_res <= w_neg1 ^ w_neg2;
         r_neg_rem <= w_neg1;
         if (w_special) begin
            r_result <= w_special_res;
         end
      end else if ((r_state == ST_MUL) && !flush_i && w_mul_last) begin
         r_result <= w_mul_res;
      end else if ((r_state == ST_DIV) && !flush_i && w_div_done) begin
         r_result <= w_div_res;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// ============================================================================
// tb_ex_muldiv : vector table and scoreboard bench for ex_muldiv (32b and 16b)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic        a_start, a_flush, a_hold, a_busy, a_wen;
   logic [2:0]  a_op;
   logic [31:0] a_op1, a_op2, a_data;
   logic [4:0]  a_rd, a_addr;

   logic        b_start, b_flush, b_hold, b_busy, b_wen;
   logic [2:0]  b_op;
   logic [15:0] b_op1, b_op2, b_data;
   logic [4:0]  b_rd, b_addr;

   ex_muldiv #(.XLEN(32), .MUL_ITER(0)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start_i(a_start), .op_i(a_op), .op1_i(a_op1),
      .op2_i(a_op2), .rd_addr_i(a_rd), .flush_i(a_flush), .hold_flag_o(a_hold),
      .busy_o(a_busy), .rd_data_o(a_data), .rd_addr_o(a_addr), .rd_wen_o(a_wen)
   );

   ex_muldiv #(.XLEN(16), .MUL_ITER(1)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start_i(b_start), .op_i(b_op), .op1_i(b_op1),
      .op2_i(b_op2), .rd_addr_i(b_rd), .flush_i(b_flush), .hold_flag_o(b_hold),
      .busy_o(b_busy), .rd_data_o(b_data), .rd_addr_o(b_addr), .rd_wen_o(b_wen)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      int          acc;
      int          lat;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   bit   mon_en = 1'b0;
   vec_t vt[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every write-back is matched to the oldest expected result
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (a_wen) begin
            if (q0.size() == 0) chk("a_unexpected_wen", 32'd1, 32'd0);
            else begin
               e0 = q0.pop_front();
               chk("a_data", a_data, e0.data);
               chk("a_addr", {27'd0, a_addr}, {27'd0, e0.addr});
               chk("a_latency", cyc - e0.acc, e0.lat);
            end
         end
         if (b_wen) begin
            if (q1.size() == 0) chk("b_unexpected_wen", 32'd1, 32'd0);
            else begin
               e1 = q1.pop_front();
               chk("b_data", {16'd0, b_data}, e1.data);
               chk("b_addr", {27'd0, b_addr}, {27'd0, e1.addr});
               chk("b_latency", cyc - e1.acc, e1.lat);
            end
         end
      end
   end

   function automatic logic [15:0] ref16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      p  = 0;
      case (op)
         INST_MUL:    begin p = ua * ub; return p[15:0];  end
         INST_MULH:   begin p = sa * sb; return p[31:16]; end
         INST_MULHSU: begin p = sa * ub; return p[31:16]; end
         INST_MULHU:  begin p = ua * ub; return p[31:16]; end
         INST_DIV: begin
            if (b == 16'h0) return 16'hFFFF;
            if (a == 16'h8000 && b == 16'hFFFF) return 16'h8000;
            p = sa / sb; return p[15:0];
         end
         INST_DIVU: begin
            if (b == 16'h0) return 16'hFFFF;
            p = ua / ub; return p[15:0];
         end
         INST_REM: begin
            if (b == 16'h0) return a;
            if (a == 16'h8000 && b == 16'hFFFF) return 16'h0000;
            p = sa % sb; return p[15:0];
         end
         default: begin
            if (b == 16'h0) return a;
            p = ua % ub; return p[15:0];
         end
      endcase
   endfunction

   function automatic logic [15:0] pick16();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h0001;
         default: return r[15:0];
      endcase
   endfunction

   task automatic wait_q0();
      int n = 0;
      while (q0.size() != 0 && n < 100) begin
         @(negedge clk); #1;
         n++;
         if (q0.size() != 0) chk("a_hold_busy", {31'd0, a_hold}, 32'd1);
      end
      if (q0.size() != 0) begin
         chk("a_timeout", 32'd1, 32'd0);
         q0.delete();
      end else begin
         chk("a_hold_done", {31'd0, a_hold}, 32'd0);
      end
   endtask

   task automatic issue0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat);
      @(posedge clk); #1;
      a_start = 1'b1; a_op = op; a_op1 = a; a_op2 = b; a_rd = rd;
      q0.push_back('{exp, rd, cyc, lat});
      @(negedge clk);
      chk("a_hold_accept", {31'd0, a_hold}, 32'd1);
      @(posedge clk); #1;
      a_start = 1'b0;
      wait_q0();
   endtask

   task automatic issue1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] rd);
      int n = 0;
      int lat;
      lat = (op[2] && (b == 16'h0 || (!op[0] && a == 16'h8000 && b == 16'hFFFF))) ? 1 : 17;
      @(posedge clk); #1;
      b_start = 1'b1; b_op = op; b_op1 = a; b_op2 = b; b_rd = rd;
      q1.push_back('{{16'd0, ref16(op, a, b)}, rd, cyc, lat});
      @(posedge clk); #1;
      b_start = 1'b0;
      while (q1.size() != 0 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      if (q1.size() != 0) begin
         chk("b_timeout", 32'd1, 32'd0);
         q1.delete();
      end
   endtask

   initial begin
      a_start = 1'b0; a_flush = 1'b0; a_op = '0; a_op1 = '0; a_op2 = '0; a_rd = '0;
      b_start = 1'b0; b_flush = 1'b0; b_op = '0; b_op1 = '0; b_op2 = '0; b_rd = '0;

      vt[0]  = '{INST_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 2};
      vt[1]  = '{INST_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 2};
      vt[2]  = '{INST_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 2};
      vt[3]  = '{INST_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 2};
      vt[4]  = '{INST_MULH,   32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 2};
      vt[5]  = '{INST_MULHSU, 32'd2,        32'hFFFFFFFF, 5'd6,  32'h00000001, 2};
      vt[6]  = '{INST_MUL,    32'h12345678, 32'h10,       5'd0,  32'h23456780, 2};
      vt[7]  = '{INST_DIV,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33};
      vt[8]  = '{INST_REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33};
      vt[9]  = '{INST_DIVU,   32'd100,      32'd7,        5'd9,  32'd14,       33};
      vt[10] = '{INST_REMU,   32'd100,      32'd7,        5'd10, 32'd2,        33};
      vt[11] = '{INST_REM,    32'd7,        32'hFFFFFFFE, 5'd11, 32'd1,        33};
      vt[12] = '{INST_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        33};
      vt[13] = '{INST_DIV,    32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1};
      vt[14] = '{INST_REMU,   32'd5,        32'd0,        5'd14, 32'd5,        1};
      vt[15] = '{INST_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1};
      vt[16] = '{INST_REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1};
      vt[17] = '{INST_DIV,    32'hFFFFFF9C, 32'd7,        5'd17, 32'hFFFFFFF2, 33};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, a_busy}, 32'd0);
      chk("rst_wen",  {31'd0, a_wen},  32'd0);
      chk("rst_data", a_data, 32'd0);
      chk("rst_addr", {27'd0, a_addr}, 32'd0);
      chk("rst_hold", {31'd0, a_hold}, 32'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < 18; i++) begin
         issue0(vt[i].op, vt[i].a, vt[i].b, vt[i].rd, vt[i].exp, vt[i].lat);
      end

      // Flush in cycle 10 of a DIV, then a fresh DIV two cycles after the abort
      @(posedge clk); #1;
      a_start = 1'b1; a_op = INST_DIV; a_op1 = 32'd1000; a_op2 = 32'd3; a_rd = 5'd20;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("flush_busy_before", {31'd0, a_busy}, 32'd1);
      a_flush = 1'b1;
      @(posedge clk); #1;
      a_flush = 1'b0;
      chk("flush_busy_after", {31'd0, a_busy}, 32'd0);
      chk("flush_hold_after", {31'd0, a_hold}, 32'd0);
      @(posedge clk);
      issue0(INST_DIV, 32'd1000, 32'd3, 5'd21, 32'd333, 33);

      // start together with flush in IDLE is not accepted
      @(posedge clk); #1;
      a_start = 1'b1; a_flush = 1'b1; a_op = INST_DIVU; a_op1 = 32'd10; a_op2 = 32'd2;
      #1;
      chk("startflush_hold", {31'd0, a_hold}, 32'd0);
      @(posedge clk); #1;
      a_start = 1'b0; a_flush = 1'b0;
      chk("startflush_busy", {31'd0, a_busy}, 32'd0);

      // Asynchronous reset in the middle of a DIV
      @(posedge clk); #1;
      a_start = 1'b1; a_op = INST_DIV; a_op1 = 32'd1000; a_op2 = 32'd7; a_rd = 5'd3;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_busy_before", {31'd0, a_busy}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, a_busy}, 32'd0);
      chk("midrst_wen",  {31'd0, a_wen},  32'd0);
      chk("midrst_data", a_data, 32'd0);
      chk("midrst_hold", {31'd0, a_hold}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_idle", {31'd0, a_busy}, 32'd0);

      // 16-bit iterative-multiplier instance against the reference model
      for (int i = 0; i < 48; i++) begin
         logic [31:0] r;
         r = $urandom;
         issue1(3'(i % 8), pick16(), pick16(), r[4:0]);
      end

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
